cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the TinyChip single-issue datapath: program counter, instruction memory, register file, ALU, data memory.
- Replaces free-running strobe toggling with one well-defined strobe sequence per instruction.
- Drives IR load, PC increment/load, register write, memory read/write and operand/writeback selects.
- Counts retired instructions and reports halt on instruction-memory end-of-file.

Parameters:
- MEM_LAT, 1, data-memory read latency in cycles; legal range 1..4.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin execution; honoured only in IDLE or HALT.
- bt  in  1  decoded bit-type: 1 = immediate form, 0 = register form.
- oc  in  3  decoded opcode.
- fn  in  1  decoded funct bit.
- cmp_eq  in  1  datapath compare result (data1 == immediate).
- eof  in  1  instruction-memory end-of-program flag.
- ir_load  out  1  latch instruction register.
- pc_inc  out  1  PC <= PC + 1.
- pc_write  out  1  PC <= jump/branch target supplied by the datapath.
- reg_write  out  1  register-file write enable.
- mem_read  out  1  data-memory read enable.
- mem_write  out  1  data-memory write enable.
- alu_b_imm  out  1  ALU operand B select: 1 = zero-extended {ro, fn}, 0 = register.
- wb_sel  out  2  writeback source: 00 ALU, 01 memory, 10 shifter.
- busy  out  1  high in every state except IDLE and HALT.
- done  out  1  high in HALT only.
- instr_count  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset (reset = 0), asynchronous: state <= IDLE, instr_count <= 0, latched class <= ALU.
  - All outputs are 0 during reset and on the first cycle after release.
  - Reset asserted mid-instruction aborts it with no further strobes.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Strobes are decoded from state plus the class latched in DECODE, and are glitch-free.
  - bt, oc and fn are sampled only in DECODE.
  - cmp_eq is sampled only in EXEC.
- Instruction classes:
  - bt = 1: oc 010 BEQ, 011 BNE, 100 LW, 101 SW, 110 SHR, 111 SHL, any other ADDI.
  - bt = 0: fn = 1 and oc = 000 is JMP; anything else is ALU-R (this includes fn = 1 with oc = 101, the clear).
- Transitions and strobes:
  - IDLE: on start, clear instr_count and go to FETCH.
  - FETCH: ir_load = 1; go to DECODE.
  - DECODE: if eof = 1, go to HALT with no PC strobe; otherwise latch the class and go to EXEC.
  - EXEC, ALU-R/ADDI: alu_b_imm = (class == ADDI); go to WB.
  - EXEC, SHR/SHL: go to WB.
  - EXEC, LW: mem_read = 1; go to MEM.
  - EXEC, SW: mem_write = 1 for exactly one cycle, plus pc_inc; go to FETCH.
  - EXEC, BEQ/BNE: branch is taken if (BEQ and cmp_eq) or (BNE and not cmp_eq). Taken asserts pc_write; not taken asserts pc_inc. Go to FETCH.
  - EXEC, JMP: pc_write; go to FETCH.
  - MEM: mem_read held high; after MEM_LAT cycles in MEM, go to WB. mem_read is therefore high for MEM_LAT + 1 consecutive cycles (EXEC plus MEM).
  - WB: reg_write = 1 and pc_inc = 1 for exactly one cycle; go to FETCH.
    - wb_sel = 01 for LW, 10 for SHR/SHL, 00 otherwise.
    - wb_sel is also driven to the same value in EXEC and MEM so the data is stable before the write.
  - HALT: done = 1; on start, clear instr_count and go to FETCH.
- Cycle costs:
  - ALU-R, ADDI, shifts: 4 cycles.
  - LW: 4 + MEM_LAT cycles.
  - SW, branch, JMP: 3 cycles.
- Invariants:
  - Exactly one of pc_inc/pc_write per retired instruction; never both in the same cycle.
  - reg_write and mem_write are never high together.
- instr_count: increments in each cycle where pc_inc or pc_write is high, and saturates at 2^CNT_W - 1 (no wrap).
- start while busy is ignored. start held high across HALT restarts every time HALT is entered.
- eof rising outside DECODE has no effect until the next DECODE.
- Illegal or unused encodings execute as ALU-R or ADDI; the FSM never deadlocks.

Test Plan:
- Reset low mid-EXEC of an ADDI -> all outputs 0 immediately; after release, state is IDLE, instr_count = 0, and no reg_write occurs.
- start, ADDI (bt=1, oc=000) -> ir_load at cycle 1, alu_b_imm at cycle 3, reg_write + pc_inc at cycle 4, instr_count = 1.
- LW with MEM_LAT = 3 -> mem_read high for 4 cycles, wb_sel = 01 from EXEC through WB, reg_write in cycle 7, no mem_write.
- BEQ with cmp_eq = 1, then BNE with cmp_eq = 1 -> first asserts pc_write only, second pc_inc only; each takes 3 cycles; instr_count = 2.
- SW followed by JMP (bt=0, fn=1, oc=000) -> mem_write exactly 1 cycle with pc_inc, then pc_write; reg_write never asserted.
- eof = 1 at DECODE after 5 instructions -> HALT, done = 1, busy = 0, instr_count = 5; start in HALT -> FETCH with instr_count cleared; CNT_W = 3 run of 9 instructions saturates at 7.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the TinyChip sequencer and its datapath.
// The sequencer takes the master side; the datapath (or a bench) the slave side.
interface cpu_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    // Datapath -> sequencer
    logic             start;
    logic             bt;
    logic [2:0]       oc;
    logic             fn;
    logic             cmp_eq;
    logic             eof;

    // Sequencer -> datapath
    logic             ir_load;
    logic             pc_inc;
    logic             pc_write;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             alu_b_imm;
    logic [1:0]       wb_sel;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  start, bt, oc, fn, cmp_eq, eof,
        output ir_load, pc_inc, pc_write, reg_write, mem_read, mem_write,
               alu_b_imm, wb_sel, busy, done, instr_count
    );

    modport slave (
        output start, bt, oc, fn, cmp_eq, eof,
        input  ir_load, pc_inc, pc_write, reg_write, mem_read, mem_write,
               alu_b_imm, wb_sel, busy, done, instr_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the TinyChip datapath. Each instruction gets one
// fixed strobe sequence, decoded from the current state plus the instruction
// class latched in DECODE. Also counts retired instructions (saturating).
module cpu_sequencer #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_sequencer_if.master       bus
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsAlu, ClsAddi, ClsBeq, ClsBne, ClsLw, ClsSw, ClsShr, ClsShl, ClsJmp
    } cls_e;

    localparam logic [2:0] MemLast = 3'(MEM_LAT - 1);

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, cls_dec;
    logic [2:0]       mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_clr;

    logic             ir_load, pc_inc, pc_write, reg_write;
    logic             mem_read, mem_write, alu_b_imm;
    logic [1:0]       wb_sel, wb_val;

    // Map the decoded instruction fields onto an execution class.
    always_comb begin
        cls_dec = ClsAlu;
        if (bus.bt) begin
            case (bus.oc)
                3'b010:  cls_dec = ClsBeq;
                3'b011:  cls_dec = ClsBne;
                3'b100:  cls_dec = ClsLw;
                3'b101:  cls_dec = ClsSw;
                3'b110:  cls_dec = ClsShr;
                3'b111:  cls_dec = ClsShl;
                default: cls_dec = ClsAddi;
            endcase
        end else if (bus.fn && bus.oc == 3'b000) begin
            cls_dec = ClsJmp;
        end
    end

    // Writeback source follows the latched class so it is stable from EXEC onwards.
    always_comb begin
        wb_val = 2'b00;
        if (cls_q == ClsLw) begin
            wb_val = 2'b01;
        end else if (cls_q == ClsShr || cls_q == ClsShl) begin
            wb_val = 2'b10;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        mem_cnt_d = mem_cnt_q;
        cnt_clr   = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_b_imm = 1'b0;
        wb_sel    = 2'b00;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    cnt_clr = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ir_load = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                if (bus.eof) begin
                    state_d = StHalt;
                end else begin
                    cls_d   = cls_dec;
                    state_d = StExec;
                end
            end
            StExec: begin
                wb_sel = wb_val;
                case (cls_q)
                    ClsLw: begin
                        mem_read  = 1'b1;
                        mem_cnt_d = 3'd0;
                        state_d   = StMem;
                    end
                    ClsSw: begin
                        mem_write = 1'b1;
                        pc_inc    = 1'b1;
                        state_d   = StFetch;
                    end
                    ClsBeq, ClsBne: begin
                        // Taken when the compare matches the branch sense.
                        if ((cls_q == ClsBeq) == bus.cmp_eq) begin
                            pc_write = 1'b1;
                        end else begin
                            pc_inc = 1'b1;
                        end
                        state_d = StFetch;
                    end
                    ClsJmp: begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end
                    ClsShr, ClsShl: begin
                        state_d = StWb;
                    end
                    default: begin
                        alu_b_imm = (cls_q == ClsAddi);
                        state_d   = StWb;
                    end
                endcase
            end
            StMem: begin
                mem_read = 1'b1;
                wb_sel   = wb_val;
                if (mem_cnt_q == MemLast) begin
                    state_d = StWb;
                end else begin
                    mem_cnt_d = mem_cnt_q + 3'd1;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                pc_inc    = 1'b1;
                wb_sel    = wb_val;
                state_d   = StFetch;
            end
            StHalt: begin
                if (bus.start) begin
                    cnt_clr = 1'b1;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Retired-instruction counter: one count per PC strobe, saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if ((pc_inc || pc_write) && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, class, memory-wait and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cls_q     <= ClsAlu;
            mem_cnt_q <= 3'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            mem_cnt_q <= mem_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.ir_load     = ir_load;
    assign bus.pc_inc      = pc_inc;
    assign bus.pc_write    = pc_write;
    assign bus.reg_write   = reg_write;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.alu_b_imm   = alu_b_imm;
    assign bus.wb_sel      = wb_sel;
    assign bus.busy        = (state_q != StIdle) && (state_q != StHalt);
    assign bus.done        = (state_q == StHalt);
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer, MEM_LAT = 3 and a 3-bit counter so that
// saturation is reachable. Outputs are sampled 1 ns after each rising edge.
module tb_cpu_sequencer;

    localparam int unsigned MEM_LAT = 3;
    localparam int unsigned CNT_W   = 3;

    // Output vector bits: {ir_load, pc_inc, pc_write, reg_write, mem_read,
    // mem_write, alu_b_imm, wb_sel[1:0], busy, done}
    localparam logic [10:0] IR  = 11'h400;
    localparam logic [10:0] PI  = 11'h200;
    localparam logic [10:0] PW  = 11'h100;
    localparam logic [10:0] RW  = 11'h080;
    localparam logic [10:0] MR  = 11'h040;
    localparam logic [10:0] MW  = 11'h020;
    localparam logic [10:0] AB  = 11'h010;
    localparam logic [10:0] WS  = 11'h008;
    localparam logic [10:0] WM  = 11'h004;
    localparam logic [10:0] BSY = 11'h002;
    localparam logic [10:0] DN  = 11'h001;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    cpu_sequencer_if #(.CNT_W(CNT_W)) bus ();

    cpu_sequencer #(
        .MEM_LAT(MEM_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] outv();
        return {bus.ir_load, bus.pc_inc, bus.pc_write, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.alu_b_imm, bus.wb_sel, bus.busy, bus.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic b, input logic [2:0] o, input logic f, input logic c);
        bus.bt     = b;
        bus.oc     = o;
        bus.fn     = f;
        bus.cmp_eq = c;
    endtask

    // Pulse start for one sampling edge; afterwards the DUT is in FETCH.
    task automatic kick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // From FETCH: raise eof so the next DECODE halts; returns in HALT.
    task automatic go_halt();
        bus.eof = 1'b1;
        tick();
        tick();
        bus.eof = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0;
        set_instr(1'b0, 3'b000, 1'b0, 1'b0);
        bus.eof = 1'b0;
        tick();
        checks++;
        if (outv() !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected %b", outv(), 11'h000);
        end
        checks++;
        if (bus.instr_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, expected 0", bus.instr_count);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (outv() !== 11'h000) begin
            errors++;
            $display("FAIL post_release_outputs: got %b, expected %b", outv(), 11'h000);
        end
        // Start an ADDI and abort it in EXEC.
        set_instr(1'b1, 3'b000, 1'b0, 1'b0);
        kick();
        tick();
        tick();
        checks++;
        if (outv() !== (AB | BSY)) begin
            errors++;
            $display("FAIL abort_exec: got %b, expected %b", outv(), AB | BSY);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (outv() !== 11'h000 || bus.instr_count !== 3'd0) begin
            errors++;
            $display("FAIL abort_immediate: got %b cnt %0d, expected %b cnt 0",
                     outv(), bus.instr_count, 11'h000);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (outv() !== 11'h000) begin
                errors++;
                $display("FAIL abort_idle cycle %0d: got %b, expected %b", c, outv(), 11'h000);
            end
        end
    endtask

    task automatic test_addi();
        logic [10:0] exp [5];
        exp = '{IR | BSY, BSY, AB | BSY, RW | PI | BSY, IR | BSY};
        set_instr(1'b1, 3'b000, 1'b0, 1'b0);
        kick();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            checks++;
            if (outv() !== exp[c]) begin
                errors++;
                $display("FAIL addi cycle %0d: got %b, expected %b", c + 1, outv(), exp[c]);
            end
        end
        checks++;
        if (bus.instr_count !== 3'd1) begin
            errors++;
            $display("FAIL addi_count: got %0d, expected 1", bus.instr_count);
        end
        go_halt();
        checks++;
        if (outv() !== DN || bus.instr_count !== 3'd1) begin
            errors++;
            $display("FAIL addi_halt: got %b cnt %0d, expected %b cnt 1",
                     outv(), bus.instr_count, DN);
        end
    endtask

    task automatic test_alu_classes();
        logic        tb_bt [5];
        logic [2:0]  tb_oc [5];
        logic        tb_fn [5];
        logic [10:0] ex_e  [5];
        logic [10:0] ex_w  [5];
        // SHR, SHL, clear (ALU-R), oc=001 immediate (ADDI), plain ALU-R
        tb_bt = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tb_oc = '{3'b110, 3'b111, 3'b101, 3'b001, 3'b000};
        tb_fn = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ex_e  = '{WS | BSY, WS | BSY, BSY, AB | BSY, BSY};
        ex_w  = '{RW | PI | WS | BSY, RW | PI | WS | BSY, RW | PI | BSY, RW | PI | BSY,
                  RW | PI | BSY};
        for (int i = 0; i < 5; i++) begin
            set_instr(tb_bt[i], tb_oc[i], tb_fn[i], 1'b0);
            if (i == 0) begin
                kick();
                checks++;
                if (bus.instr_count !== 3'd0) begin
                    errors++;
                    $display("FAIL restart_clear: got %0d, expected 0", bus.instr_count);
                end
            end
            checks++;
            if (outv() !== (IR | BSY)) begin
                errors++;
                $display("FAIL alu%0d fetch: got %b, expected %b", i, outv(), IR | BSY);
            end
            tick();
            tick();
            checks++;
            if (outv() !== ex_e[i]) begin
                errors++;
                $display("FAIL alu%0d exec: got %b, expected %b", i, outv(), ex_e[i]);
            end
            tick();
            checks++;
            if (outv() !== ex_w[i]) begin
                errors++;
                $display("FAIL alu%0d wb: got %b, expected %b", i, outv(), ex_w[i]);
            end
            tick();
        end
        checks++;
        if (bus.instr_count !== 3'd5) begin
            errors++;
            $display("FAIL alu_count: got %0d, expected 5", bus.instr_count);
        end
        go_halt();
    endtask

    task automatic test_lw();
        logic [10:0] exp [8];
        exp = '{IR | BSY, BSY, MR | WM | BSY, MR | WM | BSY, MR | WM | BSY, MR | WM | BSY,
                RW | PI | WM | BSY, IR | BSY};
        set_instr(1'b1, 3'b100, 1'b0, 1'b0);
        kick();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            checks++;
            if (outv() !== exp[c]) begin
                errors++;
                $display("FAIL lw cycle %0d: got %b, expected %b", c + 1, outv(), exp[c]);
            end
        end
        checks++;
        if (bus.instr_count !== 3'd1) begin
            errors++;
            $display("FAIL lw_count: got %0d, expected 1", bus.instr_count);
        end
        go_halt();
    endtask

    task automatic test_branch();
        logic [2:0]  b_oc  [4];
        logic        b_cmp [4];
        logic [10:0] ex_e  [4];
        b_oc  = '{3'b010, 3'b011, 3'b010, 3'b011};
        b_cmp = '{1'b1, 1'b1, 1'b0, 1'b0};
        ex_e  = '{PW | BSY, PI | BSY, PI | BSY, PW | BSY};
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b1, b_oc[i], 1'b0, b_cmp[i]);
            if (i == 0) kick();
            if (i == 2) begin
                checks++;
                if (bus.instr_count !== 3'd2) begin
                    errors++;
                    $display("FAIL branch_count2: got %0d, expected 2", bus.instr_count);
                end
            end
            checks++;
            if (outv() !== (IR | BSY)) begin
                errors++;
                $display("FAIL br%0d fetch: got %b, expected %b", i, outv(), IR | BSY);
            end
            tick();
            checks++;
            if (outv() !== BSY) begin
                errors++;
                $display("FAIL br%0d decode: got %b, expected %b", i, outv(), BSY);
            end
            tick();
            checks++;
            if (outv() !== ex_e[i]) begin
                errors++;
                $display("FAIL br%0d exec: got %b, expected %b", i, outv(), ex_e[i]);
            end
            tick();
        end
        checks++;
        if (bus.instr_count !== 3'd4) begin
            errors++;
            $display("FAIL branch_count4: got %0d, expected 4", bus.instr_count);
        end
        go_halt();
    endtask

    task automatic test_sw_jmp();
        set_instr(1'b1, 3'b101, 1'b0, 1'b0);
        kick();
        checks++;
        if (outv() !== (IR | BSY)) begin
            errors++;
            $display("FAIL sw fetch: got %b, expected %b", outv(), IR | BSY);
        end
        tick();
        bus.start = 1'b1;  // start while busy must be ignored
        tick();
        checks++;
        if (outv() !== (MW | PI | BSY)) begin
            errors++;
            $display("FAIL sw exec: got %b, expected %b", outv(), MW | PI | BSY);
        end
        bus.eof = 1'b1;    // eof outside DECODE must be ignored
        tick();
        bus.eof = 1'b0;
        bus.start = 1'b0;
        set_instr(1'b0, 3'b000, 1'b1, 1'b0);
        checks++;
        if (outv() !== (IR | BSY) || bus.instr_count !== 3'd1) begin
            errors++;
            $display("FAIL jmp fetch: got %b cnt %0d, expected %b cnt 1",
                     outv(), bus.instr_count, IR | BSY);
        end
        tick();
        checks++;
        if (outv() !== BSY) begin
            errors++;
            $display("FAIL jmp decode: got %b, expected %b", outv(), BSY);
        end
        tick();
        checks++;
        if (outv() !== (PW | BSY)) begin
            errors++;
            $display("FAIL jmp exec: got %b, expected %b", outv(), PW | BSY);
        end
        tick();
        checks++;
        if (bus.instr_count !== 3'd2) begin
            errors++;
            $display("FAIL sw_jmp_count: got %0d, expected 2", bus.instr_count);
        end
        go_halt();
    endtask

    task automatic test_halt_saturate();
        set_instr(1'b1, 3'b101, 1'b0, 1'b0);
        kick();
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            tick();
        end
        go_halt();
        checks++;
        if (outv() !== DN || bus.instr_count !== 3'd5) begin
            errors++;
            $display("FAIL halt5: got %b cnt %0d, expected %b cnt 5",
                     outv(), bus.instr_count, DN);
        end
        // Hold start high from here on: restart on every HALT entry.
        bus.start = 1'b1;
        tick();
        checks++;
        if (outv() !== (IR | BSY) || bus.instr_count !== 3'd0) begin
            errors++;
            $display("FAIL halt_restart: got %b cnt %0d, expected %b cnt 0",
                     outv(), bus.instr_count, IR | BSY);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            tick();
            tick();
            if (i == 6) begin
                checks++;
                if (bus.instr_count !== 3'd7) begin
                    errors++;
                    $display("FAIL count7: got %0d, expected 7", bus.instr_count);
                end
            end
        end
        checks++;
        if (bus.instr_count !== 3'd7) begin
            errors++;
            $display("FAIL saturate: got %0d, expected 7", bus.instr_count);
        end
        go_halt();
        checks++;
        if (outv() !== DN) begin
            errors++;
            $display("FAIL halt_held_start: got %b, expected %b", outv(), DN);
        end
        tick();
        checks++;
        if (outv() !== (IR | BSY) || bus.instr_count !== 3'd0) begin
            errors++;
            $display("FAIL held_start_restart: got %b cnt %0d, expected %b cnt 0",
                     outv(), bus.instr_count, IR | BSY);
        end
        bus.start = 1'b0;
        go_halt();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu_classes();
        test_lw();
        test_branch();
        test_sw_jmp();
        test_halt_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
